// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the shared-memory RV32I datapath.
// master = control unit (drives selects/enables), slave = datapath (supplies opcode and zero).
interface multicycle_control_fsm_if #(
    parameter int RETIRE_CNT_W = 32
) ();
    logic [6:0]              opcode;
    logic                    zero;
    logic                    pc_write;
    logic                    adr_src;
    logic                    mem_write;
    logic                    ir_write;
    logic                    reg_write;
    logic [1:0]              result_src;
    logic [1:0]              alu_src_a;
    logic [1:0]              alu_src_b;
    logic [1:0]              alu_op;
    logic                    instr_retired;
    logic [RETIRE_CNT_W-1:0] instr_count;
    logic [3:0]              state;

    modport master (
        input  opcode, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_op,
        output instr_retired, instr_count, state
    );

    modport slave (
        output opcode, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_op,
        input  instr_retired, instr_count, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RV32I core, plus retire pulse and retired-instruction counter.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unsupported opcodes lock the FSM in ILLEGAL until reset.
module multicycle_control_fsm #(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t UNSUPPORTED_NEXT = S_ILLEGAL;
`else
    localparam state_t UNSUPPORTED_NEXT = S_FETCH;
`endif

    state_t                  state_q, state_d;
    logic [RETIRE_CNT_W-1:0] count_q, count_d;

    logic       pc_update;
    logic       branch;
    logic       retire;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    // Next-state logic; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_JAL:    state_d = S_JAL;
                    OP_BRANCH: state_d = S_BEQ;
                    default:   state_d = UNSUPPORTED_NEXT;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_d = S_ILLEGAL;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode depends on state only; reset overrides with FETCH selects and no enables.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        retire     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase

        if (reset) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            retire     = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b10;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_op     = 2'b00;
        end
    end

    assign count_d = retire ? count_q + RETIRE_CNT_W'(1) : count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // zero only matters through the branch decode, i.e. in BEQ.
    assign bus.pc_write      = pc_update | (branch & bus.zero);
    assign bus.adr_src       = adr_src;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.reg_write     = reg_write;
    assign bus.result_src    = result_src;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.instr_retired = retire;
    assign bus.instr_count   = count_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class state by state.
// Outputs are sampled on the falling edge (or shortly after it), never at the rising edge.
module tb_multicycle_control_fsm;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   exp_count;

    multicycle_control_fsm_if #(.RETIRE_CNT_W(32)) bus ();

    multicycle_control_fsm #(.RETIRE_CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 7'b0000000;
        bus.zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (bus.state !== 4'd0) begin
                errors++; $display("FAIL reset_state cyc%0d got %0d exp 0", i, bus.state);
            end
            checks++;
            if ({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.instr_retired} !== 5'b0) begin
                errors++; $display("FAIL reset_enables cyc%0d got %b exp 00000", i,
                    {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.instr_retired});
            end
            checks++;
            if ({bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.adr_src} !== 9'b10_00_10_00_0) begin
                errors++; $display("FAIL reset_selects cyc%0d got %b exp 100010000", i,
                    {bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.adr_src});
            end
            checks++;
            if (bus.instr_count !== 32'd0) begin
                errors++; $display("FAIL reset_count got %0d exp 0", bus.instr_count);
            end
        end
        reset = 1'b0;
        exp_count = 0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
            errors++; $display("FAIL post_reset_fetch state %0d ir_write %b pc_write %b exp 0 1 1",
                bus.state, bus.ir_write, bus.pc_write);
        end
        $display("test_reset done");
    endtask

    task automatic test_lw();
        int exp_st[6];
        exp_st = '{0, 1, 2, 3, 4, 0};
        bus.opcode = 7'b0000011;
        bus.zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                errors++; $display("FAIL lw_state step%0d got %0d exp %0d", i, bus.state, exp_st[i]);
            end
            checks++;
            if (bus.reg_write !== (exp_st[i] == 4) || bus.instr_retired !== (exp_st[i] == 4)) begin
                errors++; $display("FAIL lw_wr_ret step%0d got %b%b exp %b%b", i, bus.reg_write,
                    bus.instr_retired, exp_st[i] == 4, exp_st[i] == 4);
            end
            if (exp_st[i] == 4) begin
                checks++;
                if (bus.result_src !== 2'b01) begin
                    errors++; $display("FAIL lw_result_src got %b exp 01", bus.result_src);
                end
            end
            if (exp_st[i] == 3) begin
                checks++;
                if (bus.adr_src !== 1'b1 || bus.result_src !== 2'b00) begin
                    errors++; $display("FAIL lw_memread adr_src %b result_src %b exp 1 00",
                        bus.adr_src, bus.result_src);
                end
            end
            if (i < 5) @(negedge clock);
        end
        exp_count++;
        checks++;
        if (bus.instr_count !== 32'(exp_count)) begin
            errors++; $display("FAIL lw_count got %0d exp %0d", bus.instr_count, exp_count);
        end
        $display("test_lw done count %0d", bus.instr_count);
    endtask

    task automatic test_sw();
        int exp_st[5];
        exp_st = '{0, 1, 2, 5, 0};
        bus.opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.state !== 4'(exp_st[i])) begin
                errors++; $display("FAIL sw_state step%0d got %0d exp %0d", i, bus.state, exp_st[i]);
            end
            checks++;
            if (bus.mem_write !== (exp_st[i] == 5) || bus.adr_src !== (exp_st[i] == 5)
                || bus.reg_write !== 1'b0 || bus.instr_retired !== (exp_st[i] == 5)) begin
                errors++; $display("FAIL sw_ctrl step%0d mw %b adr %b rw %b ret %b exp %b %b 0 %b", i,
                    bus.mem_write, bus.adr_src, bus.reg_write, bus.instr_retired,
                    exp_st[i] == 5, exp_st[i] == 5, exp_st[i] == 5);
            end
            if (i < 4) @(negedge clock);
        end
        exp_count++;
        checks++;
        if (bus.instr_count !== 32'(exp_count)) begin
            errors++; $display("FAIL sw_count got %0d exp %0d", bus.instr_count, exp_count);
        end
        $display("test_sw done count %0d", bus.instr_count);
    endtask

    task automatic test_beq();
        logic z;
        bus.opcode = 7'b1100011;
        for (int run = 0; run < 2; run++) begin
            z = (run == 0);
            bus.zero = 1'b0;
            @(negedge clock);
            bus.zero = 1'b1;
            #1;
            checks++;
            if (bus.state !== 4'd1 || bus.pc_write !== 1'b0) begin
                errors++; $display("FAIL beq_decode_zero state %0d pc_write %b exp 1 0", bus.state, bus.pc_write);
            end
            @(negedge clock);
            bus.zero = z;
            #1;
            checks++;
            if (bus.state !== 4'd10 || bus.pc_write !== z) begin
                errors++; $display("FAIL beq_pc_write zero=%b state %0d pc_write %b exp 10 %b",
                    z, bus.state, bus.pc_write, z);
            end
            checks++;
            if (bus.alu_op !== 2'b01 || bus.alu_src_a !== 2'b10 || bus.instr_retired !== 1'b1) begin
                errors++; $display("FAIL beq_ctrl alu_op %b src_a %b ret %b exp 01 10 1",
                    bus.alu_op, bus.alu_src_a, bus.instr_retired);
            end
            @(negedge clock);
            exp_count++;
            checks++;
            if (bus.state !== 4'd0 || bus.instr_count !== 32'(exp_count)) begin
                errors++; $display("FAIL beq_end state %0d count %0d exp 0 %0d", bus.state, bus.instr_count, exp_count);
            end
            $display("test_beq zero=%b done", z);
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jal_r_i();
        logic [6:0] ops[3];
        int         mid[3];
        ops = '{7'b1101111, 7'b0110011, 7'b0010011};
        mid = '{9, 6, 7};
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_count = 0;
        for (int k = 0; k < 3; k++) begin
            bus.opcode = ops[k];
            @(negedge clock);
            checks++;
            if (bus.state !== 4'd1) begin
                errors++; $display("FAIL jri_decode op%0d got %0d exp 1", k, bus.state);
            end
            @(negedge clock);
            checks++;
            if (bus.state !== 4'(mid[k]) || bus.pc_write !== (mid[k] == 9)
                || bus.alu_op !== ((mid[k] == 9) ? 2'b00 : 2'b10)) begin
                errors++; $display("FAIL jri_exec op%0d state %0d pc_write %b alu_op %b exp %0d %b %b", k,
                    bus.state, bus.pc_write, bus.alu_op, mid[k], mid[k] == 9, (mid[k] == 9) ? 2'b00 : 2'b10);
            end
            @(negedge clock);
            checks++;
            if (bus.state !== 4'd8 || bus.reg_write !== 1'b1 || bus.instr_retired !== 1'b1
                || bus.result_src !== 2'b00) begin
                errors++; $display("FAIL jri_aluwb op%0d state %0d rw %b ret %b rs %b exp 8 1 1 00", k,
                    bus.state, bus.reg_write, bus.instr_retired, bus.result_src);
            end
            @(negedge clock);
            exp_count++;
            checks++;
            if (bus.state !== 4'd0) begin
                errors++; $display("FAIL jri_end op%0d state %0d exp 0", k, bus.state);
            end
        end
        checks++;
        if (bus.instr_count !== 32'd3) begin
            errors++; $display("FAIL jri_count got %0d exp 3", bus.instr_count);
        end
        $display("test_jal_r_i done count %0d", bus.instr_count);
    endtask

    task automatic test_reset_mid();
        bus.opcode = 7'b0000011;
        for (int i = 0; i < 4; i++) @(negedge clock);
        checks++;
        if (bus.state !== 4'd4) begin
            errors++; $display("FAIL mid_reach state %0d exp 4", bus.state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.reg_write !== 1'b0 || bus.instr_retired !== 1'b0 || bus.pc_write !== 1'b0) begin
            errors++; $display("FAIL mid_reset_gate rw %b ret %b pcw %b exp 0 0 0",
                bus.reg_write, bus.instr_retired, bus.pc_write);
        end
        @(negedge clock);
        reset = 1'b0;
        exp_count = 0;
        checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== 32'd0) begin
            errors++; $display("FAIL mid_reset_after state %0d count %0d exp 0 0", bus.state, bus.instr_count);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_illegal();
        bus.opcode = 7'b1111111;
        @(negedge clock);
        checks++;
        if (bus.state !== 4'd1) begin
            errors++; $display("FAIL ill_decode got %0d exp 1", bus.state);
        end
        @(negedge clock);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.state !== 4'd11 || {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write,
                bus.instr_retired} !== 5'b0 || bus.instr_count !== 32'(exp_count)) begin
                errors++; $display("FAIL ill_stick cyc%0d state %0d count %0d exp 11 %0d",
                    i, bus.state, bus.instr_count, exp_count);
            end
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_count = 0;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++; $display("FAIL ill_recover state %0d exp 0", bus.state);
        end
`else
        checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== 32'(exp_count)) begin
            errors++; $display("FAIL ill_nop state %0d count %0d exp 0 %0d", bus.state, bus.instr_count, exp_count);
        end
`endif
        $display("test_illegal done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_count = 0;
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_jal_r_i();
        test_reset_mid();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
